// File: rtl/instr_fetch_decode_q.sv
// Parcel assembler + decoder with a PC-tagged output FIFO for the execute stage.
// Optional sticky illegal-opcode trap: define DECODE_ILLEGAL_TRAP_EN to add trap_o.
module instr_fetch_decode_q #(
  parameter int PC_W      = 16,
  parameter int OUT_DEPTH = 2,
  parameter int REG_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_parcel,
  input  logic              flush,
  input  logic [PC_W-1:0]   flush_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_opcode,
  output logic [REG_W-1:0]  out_rs1,
  output logic [REG_W-1:0]  out_rs2,
  output logic [REG_W-1:0]  out_rd,
  output logic [3:0]        out_instr,
  output logic [3:0]        out_m_type,
  output logic [2:0]        out_b_type,
  output logic [8:0]        out_offset,
  output logic              out_jump_type,
  output logic [15:0]       out_imm,
  output logic              out_ldst,
  output logic [14:0]       out_addr_offset,
  output logic              out_dest_rf,
  output logic              out_use_imm,
  output logic              out_use_addr,
  output logic              out_is_double_word,
  output logic              out_illegal,
  output logic [PC_W-1:0]   out_pc
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic              trap_o
`endif
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);

  localparam logic [2:0] OP_R = 3'd0;
  localparam logic [2:0] OP_I = 3'd1;
  localparam logic [2:0] OP_B = 3'd2;
  localparam logic [2:0] OP_J = 3'd3;
  localparam logic [2:0] OP_M = 3'd4;

  typedef enum logic {S_FIRST, S_SECOND} state_t;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [3:0]       instr;
    logic [3:0]       m_type;
    logic [2:0]       b_type;
    logic [8:0]       offset;
    logic             jump_type;
    logic [15:0]      imm;
    logic             ldst;
    logic [14:0]      addr_offset;
    logic             dest_rf;
    logic             use_imm;
    logic             use_addr;
    logic             is_double_word;
    logic             illegal;
    logic [PC_W-1:0]  pc;
  } entry_t;

  function automatic entry_t decode(input logic [15:0] p0, input logic [15:0] p1,
                                    input logic [PC_W-1:0] pc);
    entry_t d;
    d    = '0;
    d.pc = pc;
    case (p0[2:0])
      OP_R: begin
        d.opcode  = OP_R;
        d.rs1     = REG_W'(p0[5:3]);
        d.rs2     = REG_W'(p0[8:6]);
        d.rd      = REG_W'(p0[11:9]);
        d.instr   = p0[15:12];
        d.dest_rf = 1'b1;
      end
      OP_I: begin
        d.opcode         = OP_I;
        d.rs1            = REG_W'(p0[5:3]);
        d.rd             = REG_W'(p0[11:9]);
        d.instr          = p0[15:12];
        d.imm            = p1;
        d.use_imm        = 1'b1;
        d.dest_rf        = 1'b1;
        d.is_double_word = 1'b1;
      end
      OP_B: begin
        d.opcode = OP_B;
        d.rs1    = REG_W'(p0[5:3]);
        d.rs2    = REG_W'(p0[8:6]);
        d.offset = {5'b0, p0[12:9]};
        d.b_type = p0[15:13];
      end
      OP_J: begin
        d.opcode    = OP_J;
        d.offset    = {p0[15:12], p0[8:4]};
        d.jump_type = p0[6];
        d.rd        = REG_W'(p0[11:9]);
        d.dest_rf   = 1'b1;
      end
      OP_M: begin
        d.opcode         = OP_M;
        d.rd             = REG_W'(p0[11:9]);
        d.rs1            = REG_W'(p0[5:3]);
        d.rs2            = REG_W'(p0[8:6]);
        d.m_type         = p0[15:12];
        d.ldst           = p1[0];
        d.addr_offset    = p1[15:1];
        d.use_addr       = 1'b1;
        d.is_double_word = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  state_t            state_reg, state_next;
  logic [15:0]       p0_reg;
  logic [PC_W-1:0]   p0_pc_reg;
  logic [PC_W-1:0]   pc_reg;
  logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  entry_t            mem [OUT_DEPTH];
  entry_t            decoded, head;
  logic              full, accept, push, pop, latch_p0, trap_blk;

  assign full      = (count_reg == CNT_W'(OUT_DEPTH));
  assign out_valid = (count_reg != '0);
  assign pop       = out_valid && out_ready && !flush;
  // A full FIFO still takes a parcel when the head leaves in the same cycle.
  assign in_ready  = rst_n && !flush && !trap_blk && (!full || pop);
  assign accept    = in_valid && in_ready;

  always_comb begin
    if (state_reg == S_SECOND) decoded = decode(p0_reg, in_parcel, p0_pc_reg);
    else                       decoded = decode(in_parcel, 16'h0000, pc_reg);
  end

  always_comb begin
    state_next = state_reg;
    push       = 1'b0;
    latch_p0   = 1'b0;
    if (accept) begin
      case (state_reg)
        S_FIRST: begin
          if (in_parcel[2:0] == OP_I || in_parcel[2:0] == OP_M) begin
            latch_p0   = 1'b1;
            state_next = S_SECOND;
          end else begin
            push = 1'b1;
          end
        end
        S_SECOND: begin
          push       = 1'b1;
          state_next = S_FIRST;
        end
        default: state_next = S_FIRST;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FIRST;
      p0_reg    <= '0;
      p0_pc_reg <= '0;
      pc_reg    <= '0;
    end else if (flush) begin
      state_reg <= S_FIRST;
      pc_reg    <= flush_pc;
    end else begin
      state_reg <= state_next;
      if (latch_p0) begin
        p0_reg    <= in_parcel;
        p0_pc_reg <= pc_reg;
      end
      if (accept) pc_reg <= pc_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

  // Storage needs no reset: every read is masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= decoded;
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic trap_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        trap_reg <= 1'b0;
    else if (flush)                    trap_reg <= 1'b0;
    else if (push && decoded.illegal)  trap_reg <= 1'b1;
  end
  assign trap_o   = trap_reg;
  assign trap_blk = trap_reg;
`else
  assign trap_blk = 1'b0;
`endif

  always_comb begin
    head = '0;
    if (out_valid) head = mem[rd_ptr_reg];
  end

  assign out_opcode         = head.opcode;
  assign out_rs1            = head.rs1;
  assign out_rs2            = head.rs2;
  assign out_rd             = head.rd;
  assign out_instr          = head.instr;
  assign out_m_type         = head.m_type;
  assign out_b_type         = head.b_type;
  assign out_offset         = head.offset;
  assign out_jump_type      = head.jump_type;
  assign out_imm            = head.imm;
  assign out_ldst           = head.ldst;
  assign out_addr_offset    = head.addr_offset;
  assign out_dest_rf        = head.dest_rf;
  assign out_use_imm        = head.use_imm;
  assign out_use_addr       = head.use_addr;
  assign out_is_double_word = head.is_double_word;
  assign out_illegal        = head.illegal;
  assign out_pc             = head.pc;

endmodule

// File: tb/tb_instr_fetch_decode_q.sv
// Randomized + directed bench for instr_fetch_decode_q against a queue-based reference model.
module tb_instr_fetch_decode_q;
  localparam int PC_W  = 16;
  localparam int DEPTH = 2;
  localparam int REG_W = 3;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [15:0] in_parcel;
  logic [PC_W-1:0] flush_pc, out_pc;
  logic [2:0] out_opcode, out_b_type;
  logic [REG_W-1:0] out_rs1, out_rs2, out_rd;
  logic [3:0] out_instr, out_m_type;
  logic [8:0] out_offset;
  logic out_jump_type, out_ldst, out_dest_rf, out_use_imm, out_use_addr;
  logic out_is_double_word, out_illegal;
  logic [15:0] out_imm;
  logic [14:0] out_addr_offset;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic trap_o;
`endif

  instr_fetch_decode_q #(.PC_W(PC_W), .OUT_DEPTH(DEPTH), .REG_W(REG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_parcel(in_parcel), .flush(flush), .flush_pc(flush_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_instr(out_instr),
    .out_m_type(out_m_type), .out_b_type(out_b_type), .out_offset(out_offset),
    .out_jump_type(out_jump_type), .out_imm(out_imm), .out_ldst(out_ldst),
    .out_addr_offset(out_addr_offset), .out_dest_rf(out_dest_rf),
    .out_use_imm(out_use_imm), .out_use_addr(out_use_addr),
    .out_is_double_word(out_is_double_word), .out_illegal(out_illegal),
    .out_pc(out_pc)
`ifdef DECODE_ILLEGAL_TRAP_EN
    , .trap_o(trap_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: the 32-bit instruction word {p1,p0}, fields by type, everything else zero.
  function automatic logic [69:0] ref_decode(input logic [15:0] p0, input logic [15:0] p1);
    logic [31:0] w;
    logic [2:0] op, rs1, rs2, rd, btype;
    logic [3:0] fn, mt;
    logic [8:0] off;
    logic [15:0] imm;
    logic [14:0] ao;
    logic jt, ld, wrf, ui, ua, dw, ill;
    w = {p1, p0};
    op = 0; rs1 = 0; rs2 = 0; rd = 0; btype = 0; fn = 0; mt = 0; off = 0;
    imm = 0; ao = 0; jt = 0; ld = 0; wrf = 0; ui = 0; ua = 0; dw = 0; ill = 0;
    case (w[2:0])
      3'd0: begin op = 0; rs1 = w[5:3]; rs2 = w[8:6]; rd = w[11:9]; fn = w[15:12]; wrf = 1; end
      3'd1: begin op = 1; rs1 = w[5:3]; rd = w[11:9]; fn = w[15:12]; imm = w[31:16];
                  ui = 1; wrf = 1; dw = 1; end
      3'd2: begin op = 2; rs1 = w[5:3]; rs2 = w[8:6]; off = 9'(w[12:9]); btype = w[15:13]; end
      3'd3: begin op = 3; off = {w[15:12], w[8:4]}; jt = w[6]; rd = w[11:9]; wrf = 1; end
      3'd4: begin op = 4; rd = w[11:9]; rs1 = w[5:3]; rs2 = w[8:6]; mt = w[15:12];
                  ld = w[16]; ao = w[31:17]; ua = 1; dw = 1; end
      default: ill = 1;
    endcase
    return {op, rs1, rs2, rd, fn, mt, btype, off, jt, imm, ld, ao, wrf, ui, ua, dw, ill};
  endfunction

  logic [69:0] exp_q[$];
  logic [15:0] exp_pc_q[$];
  logic [15:0] m_pc, m_p0, m_p0pc;
  bit m_part, m_trap;

  task automatic model_reset();
    exp_q.delete(); exp_pc_q.delete();
    m_pc = 0; m_part = 0; m_trap = 0; m_p0 = 0; m_p0pc = 0;
  endtask

  task automatic check_outputs();
    logic [69:0] got, exp;
    logic [15:0] exp_pc;
    got = {out_opcode, out_rs1, out_rs2, out_rd, out_instr, out_m_type, out_b_type,
           out_offset, out_jump_type, out_imm, out_ldst, out_addr_offset, out_dest_rf,
           out_use_imm, out_use_addr, out_is_double_word, out_illegal};
    exp    = (exp_q.size() > 0) ? exp_q[0] : '0;
    exp_pc = (exp_pc_q.size() > 0) ? exp_pc_q[0] : '0;
    check("out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
    check("fields", 128'(got), 128'(exp));
    check("out_pc", 128'(out_pc), 128'(exp_pc));
`ifdef DECODE_ILLEGAL_TRAP_EN
    check("trap_o", 128'(trap_o), 128'(m_trap));
`endif
  endtask

  // One clock: called at a negedge, returns at the next negedge.
  task automatic step(input bit v, input logic [15:0] p, input bit ordy,
                      input bit fl, input logic [15:0] fpc);
    bit exp_rdy;
    check_outputs();
    in_valid = v; in_parcel = p; out_ready = ordy; flush = fl; flush_pc = fpc;
    #1;
    exp_rdy = !fl && !m_trap && (exp_q.size() < DEPTH || ordy);
    check("in_ready", 128'(in_ready), 128'(exp_rdy));
    if (fl) begin
      exp_q.delete(); exp_pc_q.delete();
      m_part = 0; m_pc = fpc; m_trap = 0;
      $display("flush -> pc=%h", fpc);
    end else begin
      if (exp_q.size() > 0 && ordy) begin
        $display("pop pc=%h fields=%h", exp_pc_q[0], exp_q[0]);
        void'(exp_q.pop_front()); void'(exp_pc_q.pop_front());
      end
      if (v && exp_rdy) begin
        if (m_part) begin
          exp_q.push_back(ref_decode(m_p0, p)); exp_pc_q.push_back(m_p0pc);
          m_part = 0;
        end else if (p[2:0] == 3'd1 || p[2:0] == 3'd4) begin
          m_part = 1; m_p0 = p; m_p0pc = m_pc;
        end else begin
          exp_q.push_back(ref_decode(p, 16'h0)); exp_pc_q.push_back(m_pc);
`ifdef DECODE_ILLEGAL_TRAP_EN
          if (p[2:0] >= 3'd5) m_trap = 1;
`endif
        end
        m_pc = m_pc + 16'd1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_parcel = 0; out_ready = 0; flush = 0; flush_pc = 0;
    model_reset();
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check_outputs();
    rst_n = 1;
    @(negedge clk);

    // R parcels, then explicit field checks on the first entry
    step(1, 16'h3A48, 0, 0, 0);
    check("r_rs1", 128'(out_rs1), 128'(1));
    check("r_rd", 128'(out_rd), 128'(5));
    check("r_instr", 128'(out_instr), 128'(3));
    step(1, 16'h0000, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);

    // I_TYPE across two parcels, then a parcel at pc+2
    step(1, 16'h1249, 1, 0, 0);
    step(1, 16'hBEEF, 1, 0, 0);
    check("i_imm", 128'(out_imm), 128'(16'hBEEF));
    step(1, 16'h3A48, 1, 0, 0);
    step(0, 0, 1, 0, 0);

    // M_TYPE
    step(1, 16'h5A4C, 1, 0, 0);
    step(1, 16'h8003, 1, 0, 0);
    check("m_addr", 128'(out_addr_offset), 128'(15'h4001));
    step(0, 0, 1, 0, 0);

    // Backpressure with a full FIFO, then drain
    for (int i = 0; i < 4; i++) step(1, 16'h0208 + 16'(i << 9), 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 16'h0E08, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);

    // Flush between I_TYPE parcels
    step(1, 16'h1249, 0, 0, 0);
    step(1, 16'h3A48, 0, 1, 16'h0040);
    step(1, 16'h3A48, 1, 0, 0);
    check("flush_pc", 128'(out_pc), 128'(16'h0040));
    step(0, 0, 1, 0, 0);

    // Illegal opcode, then another parcel, then flush to clear any trap
    step(1, 16'h0007, 1, 0, 0);
    check("illegal", 128'(out_illegal), 128'(1));
    step(1, 16'h3A48, 1, 0, 0);
    step(1, 16'h3A48, 1, 0, 0);
    step(0, 0, 1, 1, 16'h0100);

    // Asynchronous reset in the middle of a two-parcel instruction
    step(1, 16'h1249, 0, 0, 0);
    #3 rst_n = 0;
    #1;
    check("mid_rst_ready", 128'(in_ready), 128'(0));
    check("mid_rst_valid", 128'(out_valid), 128'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1;
    step(1, 16'h3A48, 1, 0, 0);
    step(0, 0, 1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] par;
      par = 16'($urandom);
      step($urandom_range(0, 3) != 0, par, $urandom_range(0, 2) != 0,
           $urandom_range(0, 40) == 0, 16'($urandom));
    end
    step(0, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
